// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: core-side and RAM-side buses of the memory arbiter.
// slave = arbiter view, master = cores + RAM view. Core k at [k*WIDTH +: WIDTH].
interface mem_arbiter_rr_if #(
  parameter int WIDTH    = 32,
  parameter int CORE_NUM = 4
);
  logic [CORE_NUM-1:0]       request;
  logic [CORE_NUM-1:0]       wren_core;
  logic [CORE_NUM*WIDTH-1:0] address_in;
  logic [CORE_NUM*WIDTH-1:0] data_in;
  logic [CORE_NUM*WIDTH-1:0] data_out;
  logic [CORE_NUM-1:0]       response;
  logic [WIDTH-1:0]          address;
  logic [WIDTH-1:0]          data_write;
  logic                      wren;
  logic [WIDTH-1:0]          data_read;

  modport slave (
    input  request,
    input  wren_core,
    input  address_in,
    input  data_in,
    input  data_read,
    output data_out,
    output response,
    output address,
    output data_write,
    output wren
  );

  modport master (
    output request,
    output wren_core,
    output address_in,
    output data_in,
    output data_read,
    input  data_out,
    input  response,
    input  address,
    input  data_write,
    input  wren
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: shares one single-port sync RAM among CORE_NUM cores.
// Round-robin by default; MEM_ARBITER_FIXED_PRIO_EN selects fixed priority.
// Ports: clk, rst_n (async, active-low), bus (mem_arbiter_rr_if.slave):
//   request/wren_core/address_in/data_in in, data_out/response out (per core),
//   address/data_write/wren out and data_read in (RAM side).
module mem_arbiter_rr #(
  parameter int WIDTH       = 32,
  parameter int CORE_NUM    = 4,
  parameter int RAM_LATENCY = 1
) (
  input logic             clk,
  input logic             rst_n,
  mem_arbiter_rr_if.slave bus
);

  localparam int GW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
  localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  localparam logic [CW-1:0] CNT_INIT = CW'(RAM_LATENCY - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]                r_state;
  logic [GW-1:0]             r_grant;
  logic                      r_is_wr;
  logic [CW-1:0]             r_cnt;
  logic [WIDTH-1:0]          r_address;
  logic [WIDTH-1:0]          r_data_write;
  logic                      r_wren;
  logic [CORE_NUM*WIDTH-1:0] r_data_out;
  logic [CORE_NUM-1:0]       r_response;

  logic [GW-1:0]    w_gidx;
  logic             w_found;
  logic [WIDTH-1:0] w_addr_sel;
  logic [WIDTH-1:0] w_data_sel;
  logic             w_wr_sel;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  // Lowest requesting index wins; scan high-to-low so it is assigned last.
  always_comb begin
    w_gidx  = '0;
    w_found = 1'b0;
    for (int i = CORE_NUM - 1; i >= 0; i--) begin
      if (bus.request[i]) begin
        w_gidx  = i[GW-1:0];
        w_found = 1'b1;
      end
    end
  end
`else
  localparam logic [GW-1:0] LAST_RST = GW'(CORE_NUM - 1);

  logic [GW-1:0] r_last;

  // Search last+1 .. last+CORE_NUM; scanning the offsets backwards
  // leaves the closest requester after r_last as the winner.
  always_comb begin
    int            v_sum;
    logic [GW-1:0] v_idx;
    w_gidx  = '0;
    w_found = 1'b0;
    v_sum   = 0;
    v_idx   = '0;
    for (int i = CORE_NUM; i >= 1; i--) begin
      v_sum = (int'(r_last) + i) % CORE_NUM;
      v_idx = v_sum[GW-1:0];
      if (bus.request[v_idx]) begin
        w_gidx  = v_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= LAST_RST;
    end else if (r_state == S_RESP) begin
      r_last <= r_grant;
    end
  end
`endif

  assign w_addr_sel = bus.address_in[w_gidx*WIDTH +: WIDTH];
  assign w_data_sel = bus.data_in[w_gidx*WIDTH +: WIDTH];
  assign w_wr_sel   = bus.wren_core[w_gidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_is_wr      <= 1'b0;
      r_cnt        <= '0;
      r_address    <= '0;
      r_data_write <= '0;
      r_wren       <= 1'b0;
      r_data_out   <= '0;
      r_response   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant      <= w_gidx;
            r_is_wr      <= w_wr_sel;
            r_address    <= w_addr_sel;
            r_data_write <= w_data_sel;
            r_wren       <= w_wr_sel;
            r_state      <= S_ACCESS;
          end else begin
            r_wren <= 1'b0;
          end
        end
        S_ACCESS: begin
          r_wren <= 1'b0;
          if (r_is_wr) begin
            r_response[r_grant] <= 1'b1;
            r_state             <= S_RESP;
          end else begin
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_data_out[r_grant*WIDTH +: WIDTH] <= bus.data_read;
            r_response[r_grant]                <= 1'b1;
            r_state                            <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_response <= '0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.address    = r_address;
  assign bus.data_write = r_data_write;
  assign bus.wren       = r_wren;
  assign bus.data_out   = r_data_out;
  assign bus.response   = r_response;

endmodule
